serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_adder_if.sv | 46 ++++
 rtl/serial_adder_full_adder.sv | 20 ++
 rtl/serial_adder.sv | 159 +++++++++++++++
 tb/tb_serial_adder.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and constants for the bit-serial adder.
//   sa_state_t       : controller states (IDLE, RUN, DONE)
//   SA_DEFAULT_WIDTH : default operand/result width
// Optional feature macro used by the users of this package: SERIAL_ADDER_OVF_EN
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int SA_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } sa_state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
// Request/result bundle between a requester (master) and the serial adder
// (slave).
//   start      : request strobe, sampled by the adder only in IDLE or DONE
//   a, b, cin  : operands and carry-in, captured on an accepted start
//   busy       : adder is processing bits
//   done       : one-cycle pulse, result valid
//   sum, cout  : result and final carry-out, held until the next result
//   ovf        : signed overflow (only with SERIAL_ADDER_OVF_EN defined)
// -----------------------------------------------------------------------------
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
    input  ovf,
`endif
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
    output ovf,
`endif
    output busy, done, sum, cout
  );

endinterface : serial_adder_if

// File: rtl/serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// fullAdder
// The existing 1-bit full adder cell, purely combinational.
//   A, B : operand bits
//   Cin  : carry in
//   S    : sum bit
//   Cout : carry out
// -----------------------------------------------------------------------------
module fullAdder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule : fullAdder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial WIDTH-bit adder built around a single fullAdder cell. Operands
// are captured on an accepted start and fed to the cell LSB first, one bit
// pair per clock; the cell's carry-out is registered for the next bit and each
// sum bit is shifted into a result register. {cout,sum} = a + b + cin.
//   clk    : rising-edge clock
//   rst_n  : synchronous reset, active-low (wins over start)
//   bus    : serial_adder_if.slave (start/a/b/cin in; busy/done/sum/cout out)
// Optional: SERIAL_ADDER_OVF_EN adds a registered signed-overflow flag bus.ovf.
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             fa_s_s;
  logic             fa_cout_s;
  logic             accept_s;
  logic             last_bit_s;
  logic [WIDTH-1:0] res_shifted_s;

  fullAdder u_fa (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Cin  (carry_q),
    .S    (fa_s_s),
    .Cout (fa_cout_s)
  );

  // start is honoured only when no operation is in flight
  assign accept_s      = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
  assign last_bit_s    = (cnt_q == LAST_BIT);
  // the new sum bit enters at the MSB, so after WIDTH shifts bit 0 is at [0]
  assign res_shifted_s = {fa_s_s, res_q[WIDTH-1:1]};

  // Next-state and datapath update for the controller
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          state_d = RUN;
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        res_d   = res_shifted_s;
        carry_d = fa_cout_s;
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        if (last_bit_s) begin
          // counter parked at zero instead of incrementing past WIDTH-1
          state_d = DONE;
          cnt_d   = {CW{1'b0}};
          sum_d   = res_shifted_s;
          cout_d  = fa_cout_s;
          done_d  = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
          // carry into the sign bit differs from carry out of it
          ovf_d   = carry_q ^ fa_cout_s;
`endif
        end else begin
          cnt_d   = cnt_q + 1'b1;
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= {WIDTH{1'b0}};
      b_sh_q  <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Directed bench for serial_adder at WIDTH=8. Inputs change and outputs are
// sampled 1 time unit after each rising edge. Expected values are hand-computed.
// With SERIAL_ADDER_OVF_EN defined the overflow flag is checked as well.
// -----------------------------------------------------------------------------
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int WIDTH = SA_DEFAULT_WIDTH;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  serial_adder_if #(.WIDTH(WIDTH)) bus_if ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ovf(input string tag, input logic exp);
`ifdef SERIAL_ADDER_OVF_EN
    chk(tag, {31'd0, bus_if.ovf}, {31'd0, exp});
`endif
  endtask

  // Present a request for one edge (E0), then scramble the operand inputs
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.cin   = cin;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    bus_if.a     = ~a;
    bus_if.b     = ~b;
    bus_if.cin   = ~cin;
  endtask

  task automatic expect_done(input string tag, input logic [WIDTH-1:0] es,
                             input logic ec, input logic eo);
    chk({tag, "_done"}, {31'd0, bus_if.done}, 32'd1);
    chk({tag, "_busy"}, {31'd0, bus_if.busy}, 32'd0);
    chk({tag, "_sum"},  32'(bus_if.sum),      32'(es));
    chk({tag, "_cout"}, {31'd0, bus_if.cout}, {31'd0, ec});
    chk_ovf({tag, "_ovf"}, eo);
  endtask

  // Full operation from accept through the cycle after done
  task automatic run_add(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    launch(a, b, cin);
    chk({tag, "_busy_e0"}, {31'd0, bus_if.busy}, 32'd1);
    chk({tag, "_done_e0"}, {31'd0, bus_if.done}, 32'd0);
    repeat (WIDTH - 1) tick();
    chk({tag, "_busy_e7"}, {31'd0, bus_if.busy}, 32'd1);
    chk({tag, "_done_e7"}, {31'd0, bus_if.done}, 32'd0);
    tick();
    expect_done(tag, es, ec, eo);
    tick();
    chk({tag, "_done_e9"}, {31'd0, bus_if.done}, 32'd0);
    chk({tag, "_busy_e9"}, {31'd0, bus_if.busy}, 32'd0);
    chk({tag, "_sum_held"}, 32'(bus_if.sum), 32'(es));
  endtask

  initial begin
    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.a     = 8'h00;
    bus_if.b     = 8'h00;
    bus_if.cin   = 1'b0;
    tick();
    tick();

    // reset state
    chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("rst_done", {31'd0, bus_if.done}, 32'd0);
    chk("rst_sum",  32'(bus_if.sum),      32'd0);
    chk("rst_cout", {31'd0, bus_if.cout}, 32'd0);
    chk_ovf("rst_ovf", 1'b0);

    // reset and start together: reset wins
    bus_if.a     = 8'h12;
    bus_if.b     = 8'h34;
    bus_if.start = 1'b1;
    tick();
    chk("rst_start_busy", {31'd0, bus_if.busy}, 32'd0);
    bus_if.start = 1'b0;
    rst_n        = 1'b1;
    tick();
    chk("rst_release_busy", {31'd0, bus_if.busy}, 32'd0);

    run_add("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    run_add("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_add("add7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    // reset at E4 of an operation that carries through every bit
    launch(8'hFF, 8'hFF, 1'b1);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("abort_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("abort_done", {31'd0, bus_if.done}, 32'd0);
    chk("abort_sum",  32'(bus_if.sum),      32'd0);
    chk("abort_cout", {31'd0, bus_if.cout}, 32'd0);
    chk_ovf("abort_ovf", 1'b0);
    rst_n = 1'b1;
    tick();
    chk("abort_idle_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("abort_idle_done", {31'd0, bus_if.done}, 32'd0);
    run_add("add0102", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    run_add("addcin", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

    // start during RUN at E3 is ignored
    launch(8'h11, 8'h22, 1'b0);
    repeat (2) tick();
    bus_if.a     = 8'hFF;
    bus_if.b     = 8'hFF;
    bus_if.cin   = 1'b1;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    chk("midrun_busy_e3", {31'd0, bus_if.busy}, 32'd1);
    repeat (4) tick();
    chk("midrun_done_e7", {31'd0, bus_if.done}, 32'd0);
    tick();
    expect_done("midrun", 8'h33, 1'b0, 1'b0);

    // back-to-back: start held in the DONE cycle
    bus_if.a     = 8'h80;
    bus_if.b     = 8'h80;
    bus_if.cin   = 1'b0;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    bus_if.a     = 8'h00;
    bus_if.b     = 8'h00;
    chk("b2b_busy_e0", {31'd0, bus_if.busy}, 32'd1);
    chk("b2b_done_e0", {31'd0, bus_if.done}, 32'd0);
    chk("b2b_sum_held", 32'(bus_if.sum), 32'h33);
    repeat (WIDTH - 1) tick();
    chk("b2b_busy_e7", {31'd0, bus_if.busy}, 32'd1);
    chk("b2b_done_e7", {31'd0, bus_if.done}, 32'd0);
    tick();
    expect_done("b2b", 8'h00, 1'b1, 1'b1);
    tick();
    chk("b2b_done_after", {31'd0, bus_if.done}, 32'd0);
    chk("b2b_busy_after", {31'd0, bus_if.busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_serial_adder
